// File: rtl/decoder_jp_seq.sv
// Sequenced JP nn decoder: fetches OPERAND_BYTES little-endian operand bytes over a
// ready-handshaked bus, resolves an optional condition and issues PC-load / ITABLE-reset strobes.
module decoder_jp_seq #(
    parameter int unsigned  DATA_W        = 8,
    parameter int unsigned  OPERAND_BYTES = 2,
    parameter int unsigned  COND_EN       = 1,
    localparam int unsigned SW            = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1,
    localparam int unsigned OW            = DATA_W * OPERAND_BYTES
) (
    input  logic              CLK,
    input  logic              notRESET,
    input  logic              enable,
    input  logic              cond,
    input  logic              flag,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              mem_req,
    output logic              PC_inc,
    output logic [OW-1:0]     operand,
    output logic              PR_Write_PC,
    output logic              P2_Reset_ITABLE,
    output logic              skipped,
    output logic              busy,
    output logic [SW-1:0]     step
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(OPERAND_BYTES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   step_nxt;
    logic [OW-1:0]   operand_nxt;
    logic            take;
    logic            take_nxt;

    // State and datapath registers; strobes are registered from the next-state decode.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state           <= IDLE;
            step            <= '0;
            operand         <= '0;
            take            <= 1'b0;
            mem_req         <= 1'b0;
            busy            <= 1'b0;
            PR_Write_PC     <= 1'b0;
            P2_Reset_ITABLE <= 1'b0;
            skipped         <= 1'b0;
        end else begin
            state           <= state_nxt;
            step            <= step_nxt;
            operand         <= operand_nxt;
            take            <= take_nxt;
            mem_req         <= (state_nxt == FETCH);
            busy            <= (state_nxt != IDLE);
            PR_Write_PC     <= (state_nxt == COMMIT) & take_nxt;
            P2_Reset_ITABLE <= (state_nxt == COMMIT);
            skipped         <= (state_nxt == COMMIT) & ~take_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        operand_nxt = operand;
        take_nxt    = take;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt   = FETCH;
                    step_nxt    = '0;
                    operand_nxt = '0;
                    take_nxt    = (COND_EN != 0) ? (~cond | flag) : 1'b1;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    operand_nxt[DATA_W*step +: DATA_W] = data_in;
                    if (step == LAST_STEP) begin
                        state_nxt = COMMIT;
                    end else begin
                        step_nxt = step + SW'(1);
                    end
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte consumption is visible in the same cycle the bus presents it.
    assign PC_inc = mem_req & mem_ready;

endmodule

// File: tb/tb_decoder_jp_seq.sv
// Bench for decoder_jp_seq: four instances (2/1/3/4 operand bytes, last one unconditional)
// driven in lockstep and compared every cycle against a transaction-level reference model.
module tb_decoder_jp_seq;

    localparam int unsigned NI = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cond;
    logic       flag;
    logic       mem_ready;
    logic [7:0] data_in;

    // {busy, mem_req, PC_inc, PR_Write_PC, P2_Reset_ITABLE, skipped, step[3:0], operand[31:0]}
    logic [41:0] act [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic int unsigned nb_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned ce_of(input int g);
        return (g == 3) ? 0 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned NB  = nb_of(g);
        localparam int unsigned SWL = (NB > 1) ? $clog2(NB) : 1;
        logic [8*NB-1:0] op_w;
        logic [SWL-1:0]  st_w;
        logic            mreq, pinc, prw, p2r, skp, bsy;

        decoder_jp_seq #(
            .DATA_W(8),
            .OPERAND_BYTES(NB),
            .COND_EN(ce_of(g))
        ) u_dut (
            .CLK(clk),
            .notRESET(rst_n),
            .enable(enable),
            .cond(cond),
            .flag(flag),
            .mem_ready(mem_ready),
            .data_in(data_in),
            .mem_req(mreq),
            .PC_inc(pinc),
            .operand(op_w),
            .PR_Write_PC(prw),
            .P2_Reset_ITABLE(p2r),
            .skipped(skp),
            .busy(bsy),
            .step(st_w)
        );

        assign act[g] = {bsy, mreq, pinc, prw, p2r, skp, 4'(st_w), 32'(op_w)};
    end

    // Reference model: phase 0 = waiting, 1 = collecting bytes, 2 = instruction retiring.
    int              m_phase [NI];
    int              m_got   [NI];
    longint unsigned m_op    [NI];
    bit              m_take  [NI];

    function automatic void model_reset();
        for (int g = 0; g < NI; g++) begin
            m_phase[g] = 0;
            m_got[g]   = 0;
            m_op[g]    = 0;
            m_take[g]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input int g);
        case (m_phase[g])
            0: if (enable) begin
                m_phase[g] = 1;
                m_got[g]   = 0;
                m_op[g]    = 0;
                m_take[g]  = (ce_of(g) == 0) || !cond || flag;
            end
            1: if (mem_ready) begin
                m_op[g]  = m_op[g] + (64'(data_in) << (8 * m_got[g]));
                m_got[g] = m_got[g] + 1;
                if (m_got[g] == int'(nb_of(g))) m_phase[g] = 2;
            end
            default: m_phase[g] = 0;
        endcase
    endfunction

    function automatic logic [41:0] exp_vec(input int g);
        logic       f;
        logic       c;
        logic [3:0] st;
        f  = (m_phase[g] == 1);
        c  = (m_phase[g] == 2);
        st = f ? 4'(m_got[g]) : (c ? 4'(nb_of(g) - 1) : 4'd0);
        return {m_phase[g] != 0, f, f & mem_ready, c & m_take[g], c, c & ~m_take[g], st, 32'(m_op[g])};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++)
            chk($sformatf("inst%0d outputs", g), 64'(act[g]), 64'(exp_vec(g)));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) for (int g = 0; g < NI; g++) model_step(g);
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge: asynchronous reset takes effect before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset busy",    64'(act[0][41]),    64'd0);
        chk("reset mem_req", 64'(act[0][40]),    64'd0);
        chk("reset operand", 64'(act[0][31:0]),  64'd0);
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic        en;
        logic        cnd;
        logic        flg;
        logic        rdy;
        logic [7:0]  data;
        logic        busy;
        logic        pr;
        logic        p2;
        logic        sk;
        logic [3:0]  step;
        logic [15:0] op;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int          pat      [5] = '{0, 0, 1, 0, 1};
        int          exp_step [5] = '{0, 0, 1, 1, 1};
        logic [7:0]  bytes4   [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        int          pcnt;

        rst_n = 1'b0; enable = 1'b0; cond = 1'b0; flag = 1'b0; mem_ready = 1'b0; data_in = 8'h00;
        model_reset();

        //            en cnd flg rdy data   busy pr p2 sk step op
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0034};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 16'h1234};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h1234};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h00CD};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'hABCD};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'hABCD};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'hABCD};

        @(negedge clk);
        do_reset();

        // Directed table on the 2-byte instance: unconditional jump, then a false condition.
        for (int i = 0; i < 9; i++) begin
            enable = tbl[i].en; cond = tbl[i].cnd; flag = tbl[i].flg;
            mem_ready = tbl[i].rdy; data_in = tbl[i].data;
            cycle();
            chk($sformatf("table row %0d", i),
                64'({act[0][41], act[0][38], act[0][37], act[0][36], act[0][35:32], act[0][15:0]}),
                64'({tbl[i].busy, tbl[i].pr, tbl[i].p2, tbl[i].sk, tbl[i].step, tbl[i].op}));
        end

        // Wait states, with enable asserted while busy.
        do_reset();
        enable = 1'b1; cond = 1'b0; flag = 1'b0; mem_ready = 1'b0;
        cycle();
        pcnt = 0;
        for (int k = 0; k < 5; k++) begin
            mem_ready = pat[k][0];
            enable    = (k < 2);
            cond      = 1'b1;
            flag      = 1'b0;
            data_in   = 8'(8'h40 + k);
            #1;
            if (act[0][39]) pcnt++;
            cycle();
            chk($sformatf("wait step k%0d", k), 64'(act[0][35:32]), 64'(exp_step[k]));
        end
        chk("wait PC_inc count", 64'(pcnt),        64'd2);
        chk("wait commit",       64'(act[0][37]),  64'd1);
        chk("wait take kept",    64'(act[0][38]),  64'd1);
        chk("wait operand",      64'(act[0][15:0]), 64'h4442);
        enable = 1'b1; mem_ready = 1'b0;
        cycle();
        chk("enable in commit ignored", 64'(act[0][41]), 64'd0);
        enable = 1'b0;
        cycle();

        // Reset after one of two bytes.
        enable = 1'b1; cond = 1'b0;
        cycle();
        enable = 1'b0; mem_ready = 1'b1; data_in = 8'h55;
        cycle();
        chk("mid-fetch operand", 64'(act[0][15:0]), 64'h0055);
        do_reset();
        mem_ready = 1'b0;
        cycle();

        // Parameter sweep: 1/3/4-byte assembly and the unconditional instance.
        enable = 1'b1; cond = 1'b1; flag = 1'b0; mem_ready = 1'b0;
        cycle();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1;
            data_in   = bytes4[k];
            cycle();
            if (k == 0) begin
                chk("1B operand", 64'(act[1][31:0]), 64'h12);
                chk("1B skipped", 64'(act[1][36]),   64'd1);
            end
            if (k == 2) begin
                chk("3B operand", 64'(act[2][31:0]), 64'h563412);
                chk("3B PR_Write_PC", 64'(act[2][38]), 64'd0);
            end
            if (k == 3) begin
                chk("4B operand", 64'(act[3][31:0]), 64'h78563412);
                chk("4B uncond PR_Write_PC", 64'(act[3][38]), 64'd1);
                chk("4B uncond skipped", 64'(act[3][36]), 64'd0);
            end
        end
        mem_ready = 1'b0;
        cycle();

        // Randomized traffic, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                enable    = ($urandom_range(0, 9) < 3);
                cond      = 1'($urandom);
                flag      = 1'($urandom);
                mem_ready = ($urandom_range(0, 9) < 6);
                data_in   = 8'($urandom);
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
